// File: rtl/debounce_pkg.sv
// Shared types and width helpers for the multi-channel debouncer.
package debounce_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } chan_state_e;

  // Prescaler width; CLK_DIV is at least 2 so this is always >= 1 bit.
  function automatic int presc_width(input int clk_div);
    if (clk_div <= 2) begin
      return 1;
    end else begin
      return $clog2(clk_div);
    end
  endfunction

  // Counter width; cnt never exceeds stable_cnt-1.
  function automatic int cnt_width(input int stable_cnt);
    if (stable_cnt <= 1) begin
      return 1;
    end else begin
      return $clog2(stable_cnt + 1);
    end
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: two-flop synchroniser, agreement counter, clean level and edge strobes.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   STABLE_CNT  = 4,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_tick,
  input  logic i_din,
  output logic o_dout,
  output logic o_rise,
  output logic o_fall,
  output logic o_strobe_nxt
);

  localparam int            CW       = cnt_width(STABLE_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

  logic          r_s1;
  logic          r_s2;
  logic [CW-1:0] r_cnt;
  chan_state_e   r_state;
  logic          r_dout;
  logic          r_rise;
  logic          r_fall;

  logic [CW-1:0] w_cnt_nxt;
  chan_state_e   w_state_nxt;
  logic          w_dout_nxt;
  logic          w_rise_nxt;
  logic          w_fall_nxt;

  // Two-stage synchroniser for the asynchronous raw input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= RESET_LEVEL;
      r_s2 <= RESET_LEVEL;
    end else begin
      r_s1 <= i_din;
      r_s2 <= r_s1;
    end
  end

  // Agreement counter: a level is accepted only after STABLE_CNT consecutive differing ticks.
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_state_nxt = r_state;
    w_dout_nxt  = r_dout;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    if (!i_en) begin
      w_cnt_nxt   = '0;
      w_state_nxt = STABLE;
    end else if (i_tick) begin
      if (r_s2 == r_dout) begin
        w_cnt_nxt   = '0;
        w_state_nxt = STABLE;
      end else if (r_cnt == CNT_LAST) begin
        w_dout_nxt  = r_s2;
        w_rise_nxt  = r_s2;
        w_fall_nxt  = ~r_s2;
        w_cnt_nxt   = '0;
        w_state_nxt = STABLE;
      end else begin
        w_cnt_nxt   = r_cnt + CW'(1);
        w_state_nxt = PENDING;
      end
    end else begin
      w_cnt_nxt   = r_cnt;
      w_state_nxt = r_state;
    end
  end

  // Channel state, clean level and one-clock strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_state <= STABLE;
      r_dout  <= RESET_LEVEL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_state <= w_state_nxt;
      r_dout  <= w_dout_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  assign o_dout       = r_dout;
  assign o_rise       = r_rise;
  assign o_fall       = r_fall;
  assign o_strobe_nxt = w_rise_nxt | w_fall_nxt;

endmodule

// File: rtl/multi_debouncer.sv
// Multi-channel debouncer: shared sample prescaler, per-channel debounce, combined change strobe.
module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int   CHANNELS    = 2,
  parameter int   CLK_DIV     = 100,
  parameter int   STABLE_CNT  = 4,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [CHANNELS-1:0] din,
  output logic [CHANNELS-1:0] dout,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                changed,
  output logic                sample_tick
);

  localparam int            PW        = presc_width(CLK_DIV);
  localparam logic [PW-1:0] PRESC_TOP = PW'(CLK_DIV - 1);

  logic [PW-1:0]       r_presc;
  logic                r_tick;
  logic                r_changed;
  logic [PW-1:0]       w_presc_nxt;
  logic [CHANNELS-1:0] w_strobe_nxt;

  // Prescaler next value; held at zero while disabled.
  always_comb begin
    w_presc_nxt = r_presc;
    if (!en) begin
      w_presc_nxt = '0;
    end else if (r_presc == PRESC_TOP) begin
      w_presc_nxt = '0;
    end else begin
      w_presc_nxt = r_presc + PW'(1);
    end
  end

  // Tick is registered from the next count so it is high exactly while the count sits at the top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc   <= '0;
      r_tick    <= 1'b0;
      r_changed <= 1'b0;
    end else begin
      r_presc   <= w_presc_nxt;
      r_tick    <= en & (w_presc_nxt == PRESC_TOP);
      r_changed <= |w_strobe_nxt;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debounce_channel #(
      .STABLE_CNT  (STABLE_CNT),
      .RESET_LEVEL (RESET_LEVEL)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .i_en         (en),
      .i_tick       (r_tick),
      .i_din        (din[g]),
      .o_dout       (dout[g]),
      .o_rise       (rise[g]),
      .o_fall       (fall[g]),
      .o_strobe_nxt (w_strobe_nxt[g])
    );
  end

  assign sample_tick = r_tick;
  assign changed     = r_changed;

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer with CHANNELS=2, CLK_DIV=4, STABLE_CNT=3.
module tb_multi_debouncer;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] din;
  logic [1:0] dout;
  logic [1:0] rise;
  logic [1:0] fall;
  logic       changed;
  logic       sample_tick;

  int n_chk  = 0;
  int n_pass = 0;
  int rise_cnt [2];
  int fall_cnt [2];
  int chg_cnt;
  int chg_bad;
  int tick_cnt;
  int k;

  always #5 clk = ~clk;

  multi_debouncer #(
    .CHANNELS    (2),
    .CLK_DIV     (4),
    .STABLE_CNT  (3),
    .RESET_LEVEL (1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .din         (din),
    .dout        (dout),
    .rise        (rise),
    .fall        (fall),
    .changed     (changed),
    .sample_tick (sample_tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 2; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
    end
    chg_cnt  = 0;
    chg_bad  = 0;
    tick_cnt = 0;
  endtask

  // Advance one clock and sample just after the edge, accumulating strobe activity.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (rise[i]) rise_cnt[i]++;
      if (fall[i]) fall_cnt[i]++;
    end
    if (changed) chg_cnt++;
    if (changed !== (|(rise | fall))) chg_bad++;
    if (sample_tick) tick_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    din = 2'b00;
    clr();
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", dout, 2'b00);
    check("rst_strobes", {rise, fall, changed, sample_tick}, 6'b0);
    rst = 1'b0;

    // Glitch: 6 clk high covers at most two ticks, one short of acceptance.
    clr();
    din = 2'b01;
    repeat (6) step();
    din = 2'b00;
    repeat (30) step();
    check("glitch_dout", dout, 2'b00);
    check("glitch_strobes", rise_cnt[0] + fall_cnt[0] + chg_cnt, 0);
    check("glitch_cnt", dut.g_ch[0].u_ch.r_cnt, 2'd0);

    // Clean step: latency 2 sync + 1..4 to first tick + 2 more ticks of 4 = 11..14 edges.
    clr();
    din = 2'b01;
    k = 0;
    while (dout[0] == 1'b0 && k < 40) begin
      step();
      k++;
    end
    check("step_dout", dout, 2'b01);
    check("step_latency", (k >= 11 && k <= 14), 1'b1);
    check("step_rise", rise, 2'b01);
    check("step_changed", changed, 1'b1);
    repeat (20) step();
    check("step_rise_once", rise_cnt[0], 1);
    check("step_no_other", rise_cnt[1] + fall_cnt[0] + fall_cnt[1], 0);
    check("step_chg_once", chg_cnt, 1);

    // Simultaneous opposite changes on both channels.
    clr();
    din = 2'b10;
    k = 0;
    while (dout == 2'b01 && k < 40) begin
      step();
      k++;
    end
    check("simul_dout", dout, 2'b10);
    check("simul_rise", rise, 2'b10);
    check("simul_fall", fall, 2'b01);
    check("simul_changed", changed, 1'b1);
    repeat (4) step();
    check("simul_chg_once", chg_cnt, 1);

    // Enable abort: two counted ticks on channel 1, then en low for 20 clk.
    clr();
    din = 2'b00;
    step();
    tick_cnt = 0;
    k = 0;
    while (tick_cnt < 2 && k < 20) begin
      step();
      k++;
    end
    step();
    check("en_pend_cnt", dut.g_ch[1].u_ch.r_cnt, 2'd2);
    en = 1'b0;
    tick_cnt = 0;
    repeat (20) step();
    check("en_off_ticks", tick_cnt, 0);
    check("en_off_dout", dout, 2'b10);
    check("en_off_strobes", fall_cnt[1] + chg_cnt, 0);
    check("en_off_cnt", dut.g_ch[1].u_ch.r_cnt, 2'd0);
    en = 1'b1;
    tick_cnt = 0;
    k = 0;
    while (dout[1] == 1'b1 && k < 40) begin
      step();
      k++;
    end
    check("en_resume_ticks", tick_cnt, 3);
    check("en_resume_dout", dout, 2'b00);
    check("en_resume_fall", fall, 2'b10);

    // Reset during a pending change aborts it silently.
    clr();
    din = 2'b01;
    step();
    tick_cnt = 0;
    k = 0;
    while (tick_cnt < 1 && k < 20) begin
      step();
      k++;
    end
    step();
    check("rp_pend_cnt", dut.g_ch[0].u_ch.r_cnt, 2'd1);
    #2 rst = 1'b1;
    #1;
    check("rp_dout", dout, 2'b00);
    check("rp_strobes", {rise, fall, changed, sample_tick}, 6'b0);
    check("rp_cnt", dut.g_ch[0].u_ch.r_cnt, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clr();
    k = 0;
    while (dout[0] == 1'b0 && k < 40) begin
      step();
      k++;
    end
    check("rp_after_ticks", tick_cnt, 3);
    check("rp_after_rise", rise, 2'b01);
    check("rp_after_once", rise_cnt[0] + fall_cnt[0] + fall_cnt[1], 1);

    // Asynchronous reset with din=11 clears dout without a clock edge.
    din = 2'b11;
    k = 0;
    while (dout != 2'b11 && k < 40) begin
      step();
      k++;
    end
    check("ar_pre_dout", dout, 2'b11);
    #2 rst = 1'b1;
    #1;
    check("ar_dout", dout, 2'b00);
    check("ar_strobes", {rise, fall, changed}, 5'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clr();
    repeat (8) step();
    check("ar_quiet", rise_cnt[0] + rise_cnt[1] + fall_cnt[0] + fall_cnt[1] + chg_cnt, 0);
    check("ar_quiet_dout", dout, 2'b00);
    k = 0;
    while (dout != 2'b11 && k < 40) begin
      step();
      k++;
    end
    check("ar_recover", dout, 2'b11);
    check("changed_or", chg_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
